// File: rtl/sx_axis_pkt_gen.sv
// AXI-Stream packet generator: one command in, one incrementing-byte packet out.
// Beats are built combinationally and captured into registered m_axis_* outputs.
module sx_axis_pkt_gen #(
  parameter  int DATA_WIDTH = 32,
  parameter  int ID_WIDTH   = 4,
  parameter  int DEST_WIDTH = 4,
  parameter  int LEN_WIDTH  = 16,
  localparam int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic [7:0]            cmd_seed_i,
  input  logic [ID_WIDTH-1:0]   cmd_id_i,
  input  logic [DEST_WIDTH-1:0] cmd_dest_i,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic                  m_axis_tvalid_o,
  output logic                  m_axis_tlast_o,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep_o,
  output logic [ID_WIDTH-1:0]   m_axis_tid_o,
  output logic [DEST_WIDTH-1:0] m_axis_tdest_o,
  input  logic                  m_axis_tready_i,
  output logic                  busy_o,
  output logic                  zero_len_o,
  output logic [31:0]           pkt_cnt_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  localparam logic [LEN_WIDTH-1:0] KW = LEN_WIDTH'(KEEP_WIDTH);

  logic [0:0]            r_state;
  logic [LEN_WIDTH-1:0]  r_rem;
  logic [7:0]            r_byte;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic [KEEP_WIDTH-1:0] r_tkeep;
  logic [ID_WIDTH-1:0]   r_tid;
  logic [DEST_WIDTH-1:0] r_tdest;
  logic                  r_zero;
  logic [31:0]           r_cnt;

  logic                  w_idle;
  logic                  w_accept;
  logic                  w_zero;
  logic                  w_xfer;
  logic                  w_adv;
  logic                  w_done;
  logic [LEN_WIDTH-1:0]  w_rem;
  logic [7:0]            w_base;
  logic                  w_last;
  logic [LEN_WIDTH-1:0]  w_rem_nxt;
  logic [KEEP_WIDTH-1:0] w_keep;
  logic [DATA_WIDTH-1:0] w_data;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle & cmd_valid_i & (cmd_len_i != '0);
  assign w_zero   = w_idle & cmd_valid_i & (cmd_len_i == '0);
  assign w_xfer   = (r_state == S_SEND) & r_tvalid & m_axis_tready_i;
  assign w_adv    = w_xfer & ~r_tlast;
  assign w_done   = w_xfer & r_tlast;

  // r_rem counts bytes still owed after the beat currently on the bus
  always_comb begin
    w_rem     = w_accept ? cmd_len_i : r_rem;
    w_base    = w_accept ? cmd_seed_i : r_byte;
    w_last    = (w_rem <= KW);
    w_rem_nxt = w_last ? '0 : (w_rem - KW);
    w_keep    = '0;
    w_data    = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if (LEN_WIDTH'(i) < w_rem) begin
        w_keep[i]       = 1'b1;
        w_data[8*i +: 8] = w_base + 8'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_rem    <= '0;
      r_byte   <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tkeep  <= '0;
      r_tid    <= '0;
      r_tdest  <= '0;
      r_zero   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_zero <= w_zero;
      if (w_accept) begin
        r_tid   <= cmd_id_i;
        r_tdest <= cmd_dest_i;
      end
      if (w_accept | w_adv) begin
        r_state  <= S_SEND;
        r_tvalid <= 1'b1;
        r_tdata  <= w_data;
        r_tkeep  <= w_keep;
        r_tlast  <= w_last;
        r_rem    <= w_rem_nxt;
        r_byte   <= w_base + 8'(KEEP_WIDTH);
      end else if (w_done) begin
        r_state  <= S_IDLE;
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
        r_cnt    <= r_cnt + 32'd1;
      end
    end
  end

  assign cmd_ready_o     = w_idle;
  assign busy_o          = (r_state == S_SEND);
  assign zero_len_o      = r_zero;
  assign pkt_cnt_o       = r_cnt;
  assign m_axis_tdata_o  = r_tdata;
  assign m_axis_tvalid_o = r_tvalid;
  assign m_axis_tlast_o  = r_tlast;
  assign m_axis_tkeep_o  = r_tkeep;
  assign m_axis_tid_o    = r_tid;
  assign m_axis_tdest_o  = r_tdest;

endmodule

// File: tb/tb_sx_axis_pkt_gen.sv
// Bench for sx_axis_pkt_gen: expected beats queued at command time,
// popped by a negedge monitor as the DUT hands them over.
module tb_sx_axis_pkt_gen;

  localparam int DW = 32;
  localparam int KW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [3:0]    id;
    logic [3:0]    dest;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [15:0]   cmd_len;
  logic [7:0]    cmd_seed;
  logic [3:0]    cmd_id;
  logic [3:0]    cmd_dest;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic [KW-1:0] tkeep;
  logic [3:0]    tid;
  logic [3:0]    tdest;
  logic          tready;
  logic          busy;
  logic          zero_len;
  logic [31:0]   pkt_cnt;

  beat_t sb[$];
  beat_t w_cur;
  beat_t held;
  beat_t expb;
  logic  hold_v = 1'b0;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    beats_seen = 0;
  int    exp_cnt = 0;

  sx_axis_pkt_gen #(
    .DATA_WIDTH(DW), .ID_WIDTH(4), .DEST_WIDTH(4), .LEN_WIDTH(16)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_len_i(cmd_len), .cmd_seed_i(cmd_seed),
    .cmd_id_i(cmd_id), .cmd_dest_i(cmd_dest),
    .m_axis_tdata_o(tdata), .m_axis_tvalid_o(tvalid),
    .m_axis_tlast_o(tlast), .m_axis_tkeep_o(tkeep),
    .m_axis_tid_o(tid), .m_axis_tdest_o(tdest),
    .m_axis_tready_i(tready), .busy_o(busy),
    .zero_len_o(zero_len), .pkt_cnt_o(pkt_cnt)
  );

  always #5 clk = ~clk;

  assign w_cur = {tdata, tkeep, tlast, tid, tdest};

  always @(negedge clk) begin
    if (!reset_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        n_cmp++;
        if (w_cur !== held) begin
          n_bad++;
          $display("FAIL stable: got %h want %h", w_cur, held);
        end
      end
      if (tvalid && tready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_beat: got %h want none", w_cur);
        end else begin
          expb = sb.pop_front();
          if (w_cur !== expb) begin
            n_bad++;
            $display("FAIL beat: got %h want %h", w_cur, expb);
          end
        end
        beats_seen++;
      end
      hold_v = tvalid && !tready;
      held   = w_cur;
    end
  end

  task automatic push_pkt(input int len, input int seed,
                          input int id, input int dest);
    int    nb;
    beat_t b;
    nb = (len + KW - 1) / KW;
    for (int j = 0; j < nb; j++) begin
      b      = '0;
      b.l    = (j == nb - 1);
      b.id   = 4'(id);
      b.dest = 4'(dest);
      for (int i = 0; i < KW; i++) begin
        if (j * KW + i < len) begin
          b.k[i]       = 1'b1;
          b.d[8*i +: 8] = 8'(seed + j * KW + i);
        end
      end
      sb.push_back(b);
    end
  endtask

  task automatic send_cmd(input int len, input int seed,
                          input int id, input int dest);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_len   = 16'(len);
    cmd_seed  = 8'(seed);
    cmd_id    = 4'(id);
    cmd_dest  = 4'(dest);
    if (len != 0) push_pkt(len, seed, id, dest);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !tvalid && !busy) break;
    end
    if (k == 200) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d queued want 0", nm, sb.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({tvalid, tlast, cmd_ready, busy, zero_len} !== 5'b00100) begin
      n_bad++;
      $display("FAIL rst_ctl: got %b want 00100",
               {tvalid, tlast, cmd_ready, busy, zero_len});
    end
    n_cmp++;
    if ({pkt_cnt, tdata, tkeep, tid, tdest} !== '0) begin
      n_bad++;
      $display("FAIL rst_data: got cnt=%h d=%h k=%h want 0",
               pkt_cnt, tdata, tkeep);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    tready = 1'b1;
    send_cmd(8, 8'h10, 3, 5);
    wait_drain("basic");
    exp_cnt++;
    n_cmp++;
    if (pkt_cnt !== 32'(exp_cnt)) begin
      n_bad++;
      $display("FAIL basic_cnt: got %0d want %0d", pkt_cnt, exp_cnt);
    end
  endtask

  task automatic test_wrap();
    send_cmd(5, 8'hFE, 1, 2);
    wait_drain("wrap");
    exp_cnt++;
    n_cmp++;
    if (pkt_cnt !== 32'(exp_cnt)) begin
      n_bad++;
      $display("FAIL wrap_cnt: got %0d want %0d", pkt_cnt, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    tready = 1'b0;
    send_cmd(3, 8'hA7, 6, 9);
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      tready = 1'($urandom_range(0, 1));
      if (sb.size() == 0 && !tvalid) break;
    end
    tready = 1'b1;
    wait_drain("bp");
    exp_cnt++;
    n_cmp++;
    if (pkt_cnt !== 32'(exp_cnt)) begin
      n_bad++;
      $display("FAIL bp_cnt: got %0d want %0d", pkt_cnt, exp_cnt);
    end
  endtask

  task automatic test_zero_len();
    int zc = 0;
    int vc = 0;
    int rl = 0;
    send_cmd(0, 8'h33, 2, 2);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (zero_len) zc++;
      if (tvalid) vc++;
      if (!cmd_ready) rl++;
    end
    n_cmp++;
    if (zc != 1) begin
      n_bad++;
      $display("FAIL zero_pulse: got %0d want 1", zc);
    end
    n_cmp++;
    if (vc != 0 || rl != 0) begin
      n_bad++;
      $display("FAIL zero_quiet: got valid=%0d notready=%0d want 0", vc, rl);
    end
    n_cmp++;
    if (pkt_cnt !== 32'(exp_cnt)) begin
      n_bad++;
      $display("FAIL zero_cnt: got %0d want %0d", pkt_cnt, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    int gaps = 0;
    int bad_rdy = 0;
    bit started = 0;
    int base = exp_cnt;
    tready = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_len   = 16'd6;
    cmd_seed  = 8'h40;
    cmd_id    = 4'd1;
    cmd_dest  = 4'd2;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (busy && cmd_ready) bad_rdy++;
      if (tvalid) started = 1;
      if (started && !tvalid && pkt_cnt < 32'(base + 3)) gaps++;
      if (cmd_valid && cmd_ready) begin
        push_pkt(6, 8'h40, 1, 2);
        acc++;
      end
      if (acc == 3 && cmd_valid) begin
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
      end
      if (pkt_cnt == 32'(base + 3)) break;
    end
    wait_drain("b2b");
    exp_cnt += 3;
    n_cmp++;
    if (acc != 3) begin
      n_bad++;
      $display("FAIL b2b_accepts: got %0d want 3", acc);
    end
    n_cmp++;
    if (gaps != 2) begin
      n_bad++;
      $display("FAIL b2b_gaps: got %0d want 2", gaps);
    end
    n_cmp++;
    if (bad_rdy != 0) begin
      n_bad++;
      $display("FAIL b2b_ready: got %0d busy-ready cycles want 0", bad_rdy);
    end
    n_cmp++;
    if (pkt_cnt !== 32'(exp_cnt)) begin
      n_bad++;
      $display("FAIL b2b_cnt: got %0d want %0d", pkt_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int b0 = beats_seen;
    tready = 1'b1;
    send_cmd(16, 8'h80, 4, 4);
    for (int c = 0; c < 50; c++) begin
      if (beats_seen >= b0 + 2) break;
      @(posedge clk);
    end
    #1;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({tvalid, cmd_ready, busy} !== 3'b010 || pkt_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL mid_rst: got v/r/b=%b cnt=%0d want 010 cnt=0",
               {tvalid, cmd_ready, busy}, pkt_cnt);
    end
    sb.delete();
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({tvalid, cmd_ready, busy} !== 3'b010) begin
      n_bad++;
      $display("FAIL mid_idle: got %b want 010", {tvalid, cmd_ready, busy});
    end
    send_cmd(4, 8'h21, 7, 9);
    wait_drain("mid");
    exp_cnt++;
    n_cmp++;
    if (pkt_cnt !== 32'(exp_cnt)) begin
      n_bad++;
      $display("FAIL mid_cnt: got %0d want %0d", pkt_cnt, exp_cnt);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_valid = 1'b0;
    cmd_len   = '0;
    cmd_seed  = '0;
    cmd_id    = '0;
    cmd_dest  = '0;
    tready    = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_back_to_back();
    test_reset_mid();
    n_cmp++;
    if (beats_seen < 14) begin
      n_bad++;
      $display("FAIL beat_total: got %0d want >=14", beats_seen);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
